// File: rtl/avst_seq_source.sv
// avst_seq_source: Avalon-ST source that emits a repeating arithmetic sequence
// FIRST, FIRST+STEP, ... up to LAST, then wraps back to FIRST. It uses a
// valid/ready handshake with readyLatency 0. It has enable-based start/stop
// control and a free-running count of accepted beats.
//
// Optional packet framing is selected by the macro AVST_SRC_PKT_EN. When the
// macro is defined, the sop/eop ports exist, a packet index tracks the beat
// position, and a stop request is honoured only on the beat that carries eop.
// When it is undefined, the block has no sop/eop ports and stops after any
// accepted beat.
module avst_seq_source #(
  parameter int DATA_W  = 8,
  parameter int FIRST   = 4,
  parameter int LAST    = 6,
  parameter int STEP    = 1,
  parameter int PKT_LEN = 3,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
`ifdef AVST_SRC_PKT_EN
  output logic              sop,
  output logic              eop,
`endif
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_count
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // The advance compare is done one bit wider than the data bus. This keeps
  // data+STEP from wrapping when the range sits at the top of DATA_W.
  localparam logic [DATA_W:0]   LAST_X  = (DATA_W+1)'(LAST);
  localparam logic [DATA_W:0]   STEP_X  = (DATA_W+1)'(STEP);
  localparam logic [DATA_W-1:0] FIRST_V = DATA_W'(FIRST);

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic                busy_q,  busy_d;
  logic [DATA_W-1:0]   seq_q,   seq_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;

  logic                xfer;
  logic                stop_ok;
  logic [DATA_W:0]     seq_sum;
  logic [DATA_W-1:0]   seq_nxt;

  assign xfer    = valid_q & ready;
  assign seq_sum = {1'b0, seq_q} + STEP_X;
  assign seq_nxt = (seq_sum > LAST_X) ? FIRST_V : seq_sum[DATA_W-1:0];

`ifdef AVST_SRC_PKT_EN
  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN-1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             last_beat;
  logic [IDX_W-1:0] idx_nxt;

  // A stop request is honoured only at a packet boundary. Because of this,
  // every restart begins at index 0 with sop set.
  assign last_beat = (idx_q == IDX_LAST);
  assign idx_nxt   = last_beat ? '0 : idx_q + IDX_W'(1);
  assign stop_ok   = last_beat;
`else
  assign stop_ok   = 1'b1;
`endif

  // Next-state logic: the IDLE/RUN FSM, sequence advance, and transfer counter.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
`ifdef AVST_SRC_PKT_EN
    idx_d   = idx_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        if (xfer) begin
          seq_d = seq_nxt;
          cnt_d = cnt_q + CNT_W'(1);
`ifdef AVST_SRC_PKT_EN
          idx_d = idx_nxt;
`endif
          if (!enable && stop_ok) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // valid and busy are registered copies of the next state. This keeps
    // every output coming straight from a flop.
    valid_d = (state_d == S_RUN);
    busy_d  = (state_d == S_RUN);
`ifdef AVST_SRC_PKT_EN
    sop_d   = valid_d && (idx_d == '0);
    eop_d   = valid_d && (idx_d == IDX_LAST);
`endif
  end

  // State and output registers. Reset drops any pending beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      seq_q   <= FIRST_V;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef AVST_SRC_PKT_EN
  // Packet position and framing flags. These are held while a beat is stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q <= '0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      sop_q <= sop_d;
      eop_q <= eop_d;
    end
  end

  assign sop = sop_q;
  assign eop = eop_q;
`endif

  assign valid      = valid_q;
  assign busy       = busy_q;
  assign data       = seq_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_avst_seq_source.sv
// Scoreboard bench for avst_seq_source. The stimulus pushes hand-computed beats
// into a queue. A monitor on the falling edge pops and compares each accepted
// beat. Direct checks cover reset, stall, stop, and restart behaviour. A second
// instance covers a range that sits at the top of the 8-bit space.
module tb_avst_seq_source;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       e;
  } beat_t;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic        ready;
  logic        valid,  valid2;
  logic [7:0]  data,   data2;
  logic        busy,   busy2;
  logic [15:0] xfer,   xfer2;
`ifdef AVST_SRC_PKT_EN
  logic        sop, eop, sop2, eop2;
`endif

  int    total = 0;
  int    bad   = 0;
  beat_t q[$];
  beat_t exp_b;

  avst_seq_source dut (
    .clk(clk), .resetn(resetn), .enable(enable), .ready(ready),
    .valid(valid), .data(data),
`ifdef AVST_SRC_PKT_EN
    .sop(sop), .eop(eop),
`endif
    .busy(busy), .xfer_count(xfer)
  );

  avst_seq_source #(.DATA_W(8), .FIRST(250), .LAST(255), .STEP(3)) dut2 (
    .clk(clk), .resetn(resetn), .enable(enable), .ready(ready),
    .valid(valid2), .data(data2),
`ifdef AVST_SRC_PKT_EN
    .sop(sop2), .eop(eop2),
`endif
    .busy(busy2), .xfer_count(xfer2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint got, input longint expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input bit s, input bit e);
    beat_t b;
    b.d = 8'(d);
    b.s = s;
    b.e = e;
    q.push_back(b);
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn && valid && ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        exp_b = q.pop_front();
        chk("beat_data", data, exp_b.d);
`ifdef AVST_SRC_PKT_EN
        chk("beat_sop", sop, exp_b.s);
        chk("beat_eop", eop, exp_b.e);
`endif
      end
    end
  end

  initial begin
    int resume0, resume1, stop_cnt, stop_data;
    resetn = 1'b0; enable = 1'b0; ready = 1'b0;
    repeat (2) tick();
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 4);
    chk("rst_busy", busy, 0);
    chk("rst_xfer", xfer, 0);
    chk("rst_data2", data2, 250);
    chk("rst_valid2", valid2, 0);
`ifdef AVST_SRC_PKT_EN
    chk("rst_sop", sop, 0);
    chk("rst_eop", eop, 0);
`endif
    resetn = 1'b1;
    tick();

    // Continuous run with ready held high.
    enable = 1'b1; ready = 1'b1;
    push(4,1,0); push(5,0,0); push(6,0,1);
    push(4,1,0); push(5,0,0); push(6,0,1);
    push(4,1,0);
    chk("start_idle_valid", valid, 0);
    tick();
    chk("start_valid", valid, 1);
    chk("start_data", data, 4);
    chk("start_busy", busy, 1);
    chk("top_data_0", data2, 250);
    chk("top_valid", valid2, busy2);
    tick();
    chk("top_data_1", data2, 253);
    tick();
    chk("top_data_2", data2, 250);
    chk("top_xfer", xfer2, 2);
    repeat (4) tick();
    chk("xfer_six", xfer, 6);
    chk("pending_4", data, 4);
    tick();
    chk("pending_5", data, 5);

    // Stall with 5 pending: the beat must stay put.
    ready = 1'b0;
    tick();
    chk("stall1_valid", valid, 1);
    chk("stall1_data", data, 5);
    tick();
    chk("stall2_valid", valid, 1);
    chk("stall2_data", data, 5);
    chk("stall_xfer", xfer, 7);
    ready = 1'b1;
    push(5,0,0); push(6,0,1); push(4,1,0);
    tick();
    chk("after_stall_data", data, 6);
    repeat (2) tick();
    chk("xfer_ten", xfer, 10);

    // Stop request while 5 is stalled.
    ready = 1'b0; enable = 1'b0;
    tick();
    chk("stop_hold_valid", valid, 1);
    chk("stop_hold_data", data, 5);
    ready = 1'b1;
    push(5,0,0);
`ifdef AVST_SRC_PKT_EN
    push(6,0,1);
    tick();
    chk("run_to_eop_valid", valid, 1);
    chk("run_to_eop_eop", eop, 1);
    tick();
    stop_cnt = 12; stop_data = 4; resume0 = 4; resume1 = 5;
    chk("idle_sop", sop, 0);
`else
    tick();
    stop_cnt = 11; stop_data = 6; resume0 = 6; resume1 = 4;
`endif
    chk("stopped_valid", valid, 0);
    chk("stopped_busy", busy, 0);
    chk("stopped_xfer", xfer, stop_cnt);
    chk("stopped_data", data, stop_data);
    tick();
    chk("stays_idle", valid, 0);

    // Re-enable resumes from the retained sequence value.
    enable = 1'b1;
    push(resume0, 1, 0); push(resume1, 0, 0);
    tick();
    chk("resume_data", data, resume0);
    repeat (2) tick();

    // Asynchronous reset mid-stream drops the pending beat.
    resetn = 1'b0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_data", data, 4);
    chk("arst_xfer", xfer, 0);
    chk("arst_busy", busy, 0);
    tick();
    resetn = 1'b1;
    push(4,1,0);
    tick();
    chk("restart_valid", valid, 1);
    chk("restart_data", data, 4);
`ifdef AVST_SRC_PKT_EN
    chk("restart_sop", sop, 1);
`endif
    tick();
    ready = 1'b0; enable = 1'b0;
    tick();
    chk("restart_xfer", xfer, 1);
    repeat (2) tick();
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avst_seq_source.md
# avst_seq_source

Parametrised Avalon-ST source that emits a repeating arithmetic sequence (FIRST, FIRST+STEP, … up to LAST, then wraps) with a full valid/ready handshake. It extends our fixed 4-5-6 streaming source with configurable width, range, step, start/stop control, a transfer counter and optional packet framing. It sits at the head of streaming test and bring-up pipelines as a deterministic traffic generator feeding any Avalon-ST sink.

## Interface
- DATA_W, 8, data bus width in bits.
- FIRST, 4, first sequence value. FIRST ≤ LAST.
- LAST, 6, last sequence value before wrap.
- STEP, 1, increment per accepted beat. STEP ≥ 1.
- PKT_LEN, 3, beats per packet. Used only with AVST_SRC_PKT_EN. PKT_LEN ≥ 1.
- CNT_W, 16, width of the transfer counter.

- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- enable  in  1  start/continue generation; deassert to request stop.
- ready  in  1  sink ready, readyLatency 0.
- valid  out  1  beat on data is valid.
- data  out  DATA_W  current sequence value.
- sop  out  1  start of packet (only with AVST_SRC_PKT_EN).
- eop  out  1  end of packet (only with AVST_SRC_PKT_EN).
- busy  out  1  high in RUN state.
- xfer_count  out  CNT_W  number of accepted beats since reset, wraps modulo 2^CNT_W.

## Operation
- All outputs registered. Reset values: valid=0, data=FIRST, sop=0, eop=0, busy=0, xfer_count=0; internal sequence and packet index return to FIRST / 0.
- States: IDLE, RUN.
- IDLE: valid=0. If enable=1 at a clock edge → RUN; valid=1 and data=current sequence value from the next cycle.
- RUN: transfer occurs in any cycle with valid=1 and ready=1. On transfer: xfer_count+1; data advances.
- Advance rule: if data > LAST−STEP (i.e. data+STEP would exceed LAST) next data = FIRST, else data+STEP. Compare in DATA_W+1 bits so no overflow at the top of the DATA_W range.
- Stall: while valid=1 and ready=0, data, sop, eop held stable; valid never drops until the beat is accepted.
- Stop: enable=0 is a request. Without framing, the FSM leaves RUN after the next accepted beat (or immediately if none pending is impossible: valid is always high in RUN, so it waits for acceptance). The sequence value is retained; next start resumes from the following value, not FIRST.
- Simultaneous transfer and enable=0: that transfer completes, valid=0 next cycle, state IDLE.
- Reset mid-stream: immediate return to reset values; any unaccepted beat is dropped.

## Timing
- Start latency: enable sampled high in IDLE at edge N → valid=1 after edge N.
- Throughput: one beat per cycle with ready held high.
- Stop latency: valid=0 the cycle after the final accepted beat.
- xfer_count updates on the edge that accepts the beat.

## Configuration
- AVST_SRC_PKT_EN defined: sop/eop ports exist. sop=1 on packet beat index 0, eop=1 on index PKT_LEN−1 (both on the same beat when PKT_LEN=1). Packet index advances on transfer, wraps after eop. Stop honoured only on the transfer carrying eop; start always begins with sop=1. Sequence value runs independently of packet index.
- Not defined: no sop/eop ports, no packet index; stop after any accepted beat.

## Test plan
- Defaults, reset release, enable=1, ready=1 → valid from cycle after enable; data 4,5,6,4,5,6; xfer_count 6 after six beats.
- ready toggling 1,0,0,1 with data=5 pending → data stays 5 and valid stays 1 across stall; next accepted beat is 6.
- DATA_W=8, FIRST=250, LAST=255, STEP=3 → data 250,253,250 (no 8-bit overflow).
- enable dropped while data=5 stalled → beat 5 accepted when ready=1, valid=0 next cycle; re-enable resumes with 6.
- AVST_SRC_PKT_EN, PKT_LEN=3, enable dropped on beat 2 → emission continues to eop beat, sop/eop = (1,0),(0,0),(0,1), then idle.
- resetn pulsed low mid-stream → valid=0, data=4, xfer_count=0 asynchronously; restart yields 4 with sop=1.
